// File: rtl/trsram_dn_arbiter.sv
// Shares the trs80 download port between the CMD loader and cassette streams.
// Each source is buffered in a small FIFO; writes issue only in core-signalled RAM-free slots.
module trsram_dn_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAIL_CYC = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ld_download,
    input  logic        ld_wr,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_wait,
    input  logic        cas_download,
    input  logic        cas_wr,
    input  logic [15:0] cas_addr,
    input  logic [7:0]  cas_data,
    output logic        cas_wait,
    input  logic        dn_slot,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [23:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TAIL_CYC + 1);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StTail} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tail_cnt_q, tail_cnt_d;

    // Index 0 is the loader, index 1 the cassette; entries hold {addr16, data8}.
    logic [23:0]   mem_q [2][DEPTH];
    logic [23:0]   mem_d [2][DEPTH];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    wait_q, wait_d;
    logic          overflow_q, overflow_d;
    logic          last_grant_q, last_grant_d;
    logic          dn_wr_q, dn_wr_d;
    logic [23:0]   dn_addr_q, dn_addr_d;
    logic [7:0]    dn_data_q, dn_data_d;

    logic [1:0]    push, pop, nonempty;
    logic [23:0]   push_word [2];
    logic          issue_en, gsel, any_dl, fifos_idle;
    logic [23:0]   head_word;

    assign push         = {cas_wr, ld_wr};
    assign push_word[0] = {ld_addr, ld_data};
    assign push_word[1] = {cas_addr, cas_data};
    assign any_dl       = ld_download | cas_download;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (cnt_q[s] != '0);
        end
        if (&nonempty) begin
            gsel = ~last_grant_q;
        end else begin
            gsel = nonempty[1];
        end
        issue_en  = ((state_q == StActive) || (state_q == StDrain)) && dn_slot && (|nonempty);
        pop       = issue_en ? (gsel ? 2'b10 : 2'b01) : 2'b00;
        head_word = mem_q[gsel][rptr_q[gsel]];
    end

    always_comb begin
        logic full, acc;
        mem_d      = mem_q;
        overflow_d = overflow_q;
        for (int s = 0; s < 2; s++) begin
            rptr_d[s] = rptr_q[s];
            wptr_d[s] = wptr_q[s];
            cnt_d[s]  = cnt_q[s];
            full      = (cnt_q[s] == CW'(DEPTH));
            // A pop frees the slot the push lands in, so full+push+pop is lossless.
            acc       = push[s] && (!full || pop[s]);
            if (acc) begin
                mem_d[s][wptr_q[s]] = push_word[s];
                wptr_d[s]           = wptr_q[s] + PW'(1);
            end
            if (pop[s]) begin
                rptr_d[s] = rptr_q[s] + PW'(1);
            end
            if (push[s] && full && !pop[s]) begin
                overflow_d = 1'b1;
            end
            case ({acc, pop[s]})
                2'b10:   cnt_d[s] = cnt_q[s] + CW'(1);
                2'b01:   cnt_d[s] = cnt_q[s] - CW'(1);
                default: cnt_d[s] = cnt_q[s];
            endcase
            wait_d[s] = (cnt_q[s] >= CW'(DEPTH - 1));
        end
    end

    always_comb begin
        dn_wr_d      = issue_en;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        last_grant_d = last_grant_q;
        if (issue_en) begin
            dn_addr_d    = {7'h00, gsel, head_word[23:8]};
            dn_data_d    = head_word[7:0];
            last_grant_d = gsel;
        end
    end

    // An empty FIFO pair with no push pending means nothing is left to grant.
    assign fifos_idle = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (push == 2'b00);

    always_comb begin
        state_d    = state_q;
        tail_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (any_dl) state_d = StActive;
            end
            StActive: begin
                if (!any_dl) state_d = StDrain;
            end
            StDrain: begin
                if (any_dl) begin
                    state_d = StActive;
                end else if (fifos_idle) begin
                    state_d = StTail;
                end
            end
            StTail: begin
                if (any_dl) begin
                    state_d = StActive;
                end else if (tail_cnt_q == TW'(TAIL_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    tail_cnt_d = tail_cnt_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            tail_cnt_q   <= '0;
            rptr_q       <= '{default: '0};
            wptr_q       <= '{default: '0};
            cnt_q        <= '{default: '0};
            wait_q       <= '0;
            overflow_q   <= 1'b0;
            last_grant_q <= 1'b1;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            tail_cnt_q   <= tail_cnt_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign dn_go    = (state_q != StIdle);
    assign dn_wr    = dn_wr_q;
    assign dn_addr  = dn_addr_q;
    assign dn_data  = dn_data_q;
    assign ld_wait  = wait_q[0];
    assign cas_wait = wait_q[1];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_trsram_dn_arbiter.sv
// Scoreboard bench for trsram_dn_arbiter: expected writes are queued as bytes are pushed
// and checked in order when dn_wr fires.
module tb_trsram_dn_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ld_download = 1'b0, ld_wr = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_wait;
    logic        cas_download = 1'b0, cas_wr = 1'b0;
    logic [15:0] cas_addr = '0;
    logic [7:0]  cas_data = '0;
    logic        cas_wait;
    logic        dn_slot = 1'b0;
    logic        dn_go, dn_wr, overflow;
    logic [23:0] dn_addr;
    logic [7:0]  dn_data;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_wr = 0;
    int   cyc = 0;
    int   go_zero = 0;
    logic go_watch = 1'b0;

    trsram_dn_arbiter #(.DEPTH(4), .TAIL_CYC(8)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ld_download  (ld_download),
        .ld_wr        (ld_wr),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_wait      (ld_wait),
        .cas_download (cas_download),
        .cas_wr       (cas_wr),
        .cas_addr     (cas_addr),
        .cas_data     (cas_data),
        .cas_wait     (cas_wait),
        .dn_slot      (dn_slot),
        .dn_go        (dn_go),
        .dn_wr        (dn_wr),
        .dn_addr      (dn_addr),
        .dn_data      (dn_data),
        .overflow     (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        if (dn_wr === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(dn_wr), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(dn_addr), 32'(e.addr));
                chk("wr_data", 32'(dn_data), 32'(e.data));
                if (e.cyc >= 0) chk("wr_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (go_watch && dn_go !== 1'b1) go_zero++;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
        ld_wr  = 1'b0;
        cas_wr = 1'b0;
    endtask

    task automatic push_ld(input logic [15:0] a, input logic [7:0] d, input bit keep, input int ecyc);
        ld_wr   = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (keep) exp_q.push_back('{addr: {8'h00, a}, data: d, cyc: ecyc});
    endtask

    task automatic push_cas(input logic [15:0] a, input logic [7:0] d);
        cas_wr   = 1'b1;
        cas_addr = a;
        cas_data = d;
        exp_q.push_back('{addr: {8'h01, a}, data: d, cyc: -1});
    endtask

    // Returns mid-cycle just after the edge following the last expected write.
    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(posedge clk_sys);
            i++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
        ld_wr  = 1'b0;
        cas_wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, nw0;

        // Reset state
        tick();
        tick();
        @(negedge clk_sys);
        chk("rst_dn_go", 32'(dn_go), 32'd0);
        chk("rst_dn_wr", 32'(dn_wr), 32'd0);
        chk("rst_dn_addr", 32'(dn_addr), 32'd0);
        chk("rst_dn_data", 32'(dn_data), 32'd0);
        chk("rst_waits", 32'({ld_wait, cas_wait}), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;

        // 1: loader only, slot always free, minimum latency and tail window
        dn_slot     = 1'b1;
        ld_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            push_ld(16'h5200 + 16'(i), 8'hA0 + 8'(i), 1'b1, cyc + 2);
            tick();
        end
        ld_download = 1'b0;
        wait_drain("t1_drained");
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (dn_go !== 1'b1) break;
            hi++;
        end
        chk("t1_tail_len", 32'(hi), 32'd8);
        chk("t1_go_low", 32'(dn_go), 32'd0);

        // 2: contention after reset, loader wins first
        tick();
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        dn_slot      = 1'b0;
        ld_download  = 1'b1;
        cas_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_ld(16'h6000 + 16'(i), 8'hB0 + 8'(i), 1'b1, -1);
            push_cas(16'h0100 + 16'(i), 8'hC0 + 8'(i));
            tick();
        end
        dn_slot = 1'b1;
        tick();
        ld_download  = 1'b0;
        cas_download = 1'b0;
        wait_drain("t2_drained");
        repeat (12) tick();

        // 3: slot starvation then sparse slots
        dn_slot     = 1'b0;
        ld_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_ld(16'h7000 + 16'(i), 8'hD0 + 8'(i), 1'b1, -1);
            if (i == 2) begin
                @(negedge clk_sys);
                chk("t3_wait_early", 32'(ld_wait), 32'd0);
            end
            tick();
        end
        nw0 = n_wr;
        repeat (4) tick();
        chk("t3_starve_nowr", 32'(n_wr - nw0), 32'd0);
        @(negedge clk_sys);
        chk("t3_wait_full", 32'(ld_wait), 32'd1);
        for (int k = 0; k < 4; k++) begin
            dn_slot = 1'b1;
            tick();
            dn_slot = 1'b0;
            nw0 = n_wr;
            repeat (3) tick();
            chk("t3_one_per_slot", 32'(n_wr - nw0), 32'd1);
        end
        chk("t3_all_written", 32'(exp_q.size()), 32'd0);

        // 4: overflow, fifth byte dropped
        for (int i = 0; i < 5; i++) begin
            push_ld(16'h7100 + 16'(i), 8'hE0 + 8'(i), (i < 4), -1);
            if (i == 4) begin
                @(negedge clk_sys);
                chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
            end
            tick();
        end
        @(negedge clk_sys);
        chk("t4_overflow", 32'(overflow), 32'd1);
        tick();
        dn_slot     = 1'b1;
        ld_download = 1'b0;
        wait_drain("t4_drained");

        // 5: re-arm in TAIL cycle 3
        go_watch = 1'b1;
        @(negedge clk_sys);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        tick();
        tick();
        cas_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_cas(16'h0200 + 16'(i), 8'h90 + 8'(i));
            tick();
        end
        tick();
        cas_download = 1'b0;
        wait_drain("t5_drained");
        go_watch = 1'b0;
        chk("t5_go_held", 32'(go_zero), 32'd0);
        repeat (12) tick();

        // 6: reset coincident with a grant
        dn_slot      = 1'b0;
        ld_download  = 1'b1;
        cas_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_ld(16'h7800 + 16'(i), 8'h10 + 8'(i), 1'b1, -1);
            push_cas(16'h0300 + 16'(i), 8'h20 + 8'(i));
            tick();
        end
        tick();
        @(negedge clk_sys);
        chk("t6_waits_set", 32'({ld_wait, cas_wait}), 32'd3);
        tick();
        dn_slot = 1'b1;
        reset   = 1'b1;
        exp_q.delete();
        tick();
        reset        = 1'b0;
        ld_download  = 1'b0;
        cas_download = 1'b0;
        @(negedge clk_sys);
        chk("t6_dn_wr", 32'(dn_wr), 32'd0);
        chk("t6_dn_go", 32'(dn_go), 32'd0);
        chk("t6_waits", 32'({ld_wait, cas_wait}), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        tick();
        ld_download = 1'b1;
        nw0 = n_wr;
        repeat (6) tick();
        chk("t6_flushed", 32'(n_wr - nw0), 32'd0);
        ld_download = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
